pcie_egress: RTL and testbench

PCIE_EGRESS -- requirements
Module: pcie_egress

---
 rtl/pcie_egress_pkg.sv | 52 +++++
 rtl/egress_contadores.sv | 59 +++++
 rtl/pcie_egress.sv | 152 +++++++++++++++
 tb/tb_pcie_egress.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_egress_pkg.sv
// Shared types and constants for the PCIe egress arbiter: FSM encoding, word field layout, defaults.
// The optional destination check is enabled by defining EGRESS_DEST_CHECK_EN.
package pcie_egress_pkg;

   localparam int TAMANO_DATOS_DEF = 12;
   localparam int CONT_W_DEF       = 5;
   localparam int NPORTS           = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_CAPT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   localparam int CLASS_HI   = 11;
   localparam int CLASS_LO   = 10;
   localparam int DEST_HI    = 9;
   localparam int DEST_LO    = 8;
   localparam int PAYLOAD_HI = 7;
   localparam int PAYLOAD_LO = 0;

   function automatic logic [1:0] class_of(input logic [TAMANO_DATOS_DEF-1:0] w);
      return w[CLASS_HI:CLASS_LO];
   endfunction

   function automatic logic [1:0] dest_of(input logic [TAMANO_DATOS_DEF-1:0] w);
      return w[DEST_HI:DEST_LO];
   endfunction

   function automatic logic [7:0] payload_of(input logic [TAMANO_DATOS_DEF-1:0] w);
      return w[PAYLOAD_HI:PAYLOAD_LO];
   endfunction

   // First available port strictly after 'last', wrapping 3 -> 0.
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] avail);
      logic [1:0] cand;
      logic [1:0] pick;
      logic       found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NPORTS; k++) begin
         cand = last + 2'(k);
         if (!found && avail[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/egress_contadores.sv
// Per-port transfer counters with a registered read port; a read colliding with an
// increment of the same counter returns the pre-increment value.
module egress_contadores
   import pcie_egress_pkg::*;
#(
   parameter int CONT_W = CONT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic [1:0]        inc_idx,
   input  logic              req,
   input  logic [1:0]        idx,
   output logic [CONT_W-1:0] cnt_out,
   output logic              cnt_valid
);

   logic [CONT_W-1:0] cnt_q [NPORTS];
   logic [CONT_W-1:0] cnt_d [NPORTS];
   logic [CONT_W-1:0] cnt_out_q, cnt_out_d;
   logic              cnt_valid_q, cnt_valid_d;

   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc && inc_idx == 2'(i)) begin
            cnt_d[i] = cnt_q[i] + CONT_W'(1);
         end
      end
   end

   always_comb begin
      cnt_out_d   = cnt_out_q;
      cnt_valid_d = req;
      if (req) begin
         cnt_out_d = cnt_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NPORTS; i++) begin
            cnt_q[i] <= '0;
         end
         cnt_out_q   <= '0;
         cnt_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         cnt_out_q   <= cnt_out_d;
         cnt_valid_q <= cnt_valid_d;
      end
   end

   assign cnt_out   = cnt_out_q;
   assign cnt_valid = cnt_valid_q;

endmodule

// File: rtl/pcie_egress.sv
// Round-robin egress arbiter over FIFOs 4..7 with a valid/ready output stage and per-port counters.
// Define EGRESS_DEST_CHECK_EN to flag words whose DEST field disagrees with their source port.
module pcie_egress
   import pcie_egress_pkg::*;
#(
   parameter int TAMANO_DATOS = TAMANO_DATOS_DEF,
   parameter int CONT_W       = CONT_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              empty,
   input  logic [TAMANO_DATOS-1:0] data_in4,
   input  logic [TAMANO_DATOS-1:0] data_in5,
   input  logic [TAMANO_DATOS-1:0] data_in6,
   input  logic [TAMANO_DATOS-1:0] data_in7,
   output logic [3:0]              pop,
   output logic [TAMANO_DATOS-1:0] data_out,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic [1:0]              port_out,
   input  logic                    req,
   input  logic [1:0]              idx,
   output logic [CONT_W-1:0]       cnt_out,
   output logic                    cnt_valid,
   output logic                    dest_err
);

   state_t                  state_q, state_d;
   logic [1:0]              sel_q, sel_d;
   logic [1:0]              rr_ptr_q, rr_ptr_d;
   logic [1:0]              port_out_q, port_out_d;
   logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;
   logic [TAMANO_DATOS-1:0] data_sel;
   logic                    any_avail;
   logic                    sel_avail;
   logic                    xfer;

   assign any_avail = ~&empty;
   assign sel_avail = ~empty[sel_q];
   assign xfer      = (state_q == ST_OUT) && ready_in;

   always_comb begin
      case (sel_q)
         2'd0:    data_sel = data_in4;
         2'd1:    data_sel = data_in5;
         2'd2:    data_sel = data_in6;
         default: data_sel = data_in7;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A port that went empty between the pick and the pop is dropped back to IDLE unread.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_avail) state_d = ST_POP;
         ST_POP:  state_d = sel_avail ? ST_CAPT : ST_IDLE;
         ST_CAPT: state_d = ST_OUT;
         ST_OUT:  if (ready_in) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pop       = 4'b0000;
      valid_out = 1'b0;
      case (state_q)
         ST_POP:  if (sel_avail) pop[sel_q] = 1'b1;
         ST_OUT:  valid_out = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      data_out_d = data_out_q;
      port_out_d = port_out_q;
      if (state_q == ST_IDLE && any_avail) begin
         sel_d = rr_pick(rr_ptr_q, ~empty);
      end
      if (state_q == ST_POP && sel_avail) begin
         rr_ptr_d = sel_q;
      end
      // The FIFO read data is valid in the cycle after pop.
      if (state_q == ST_CAPT) begin
         data_out_d = data_sel;
         port_out_d = sel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q      <= 2'd0;
         rr_ptr_q   <= 2'd3;
         data_out_q <= '0;
         port_out_q <= 2'd0;
      end else begin
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         data_out_q <= data_out_d;
         port_out_q <= port_out_d;
      end
   end

   assign data_out = data_out_q;
   assign port_out = port_out_q;

`ifdef EGRESS_DEST_CHECK_EN
   logic dest_err_q, dest_err_d;

   always_comb begin
      dest_err_d = dest_err_q;
      if (state_q == ST_CAPT && dest_of(data_sel) != sel_q) begin
         dest_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dest_err_q <= 1'b0;
      end else begin
         dest_err_q <= dest_err_d;
      end
   end

   assign dest_err = dest_err_q;
`else
   assign dest_err = 1'b0;
`endif

   egress_contadores #(
      .CONT_W (CONT_W)
   ) u_contadores (
      .clk       (clk),
      .reset     (reset),
      .inc       (xfer),
      .inc_idx   (sel_q),
      .req       (req),
      .idx       (idx),
      .cnt_out   (cnt_out),
      .cnt_valid (cnt_valid)
   );

endmodule

// File: tb/tb_pcie_egress.sv
// Self-checking bench for pcie_egress: emulated source FIFOs, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_pcie_egress;

   localparam int DW = 12;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    empty;
   logic [DW-1:0] data_in4, data_in5, data_in6, data_in7;
   logic [3:0]    pop;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          ready_in;
   logic [1:0]    port_out;
   logic          req;
   logic [1:0]    idx;
   logic [CW-1:0] cnt_out;
   logic          cnt_valid;
   logic          dest_err;

   always #5 clk = ~clk;

   pcie_egress #(
      .TAMANO_DATOS (DW),
      .CONT_W       (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .empty     (empty),
      .data_in4  (data_in4),
      .data_in5  (data_in5),
      .data_in6  (data_in6),
      .data_in7  (data_in7),
      .pop       (pop),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .port_out  (port_out),
      .req       (req),
      .idx       (idx),
      .cnt_out   (cnt_out),
      .cnt_valid (cnt_valid),
      .dest_err  (dest_err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [DW-1:0] fifo_q [4][$];
   logic [DW-1:0] rd_word [4];
   int            pop_log[$];
   int            pop_cyc[$];

   assign data_in4 = rd_word[0];
   assign data_in5 = rd_word[1];
   assign data_in6 = rd_word[2];
   assign data_in7 = rd_word[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic upd_empty();
      for (int i = 0; i < 4; i++) empty[i] = (fifo_q[i].size() == 0);
   endtask

   // One clock; the emulated FIFOs present the popped word one cycle after pop.
   task automatic tick();
      logic [3:0] p;
      p = pop;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (p[i] && fifo_q[i].size() > 0) begin
            rd_word[i] = fifo_q[i].pop_front();
            pop_log.push_back(i);
            pop_cyc.push_back(cyc);
         end
      end
      upd_empty();
   endtask

   task automatic load(input int port, input logic [DW-1:0] w);
      fifo_q[port].push_back(w);
      upd_empty();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) fifo_q[i].delete();
      upd_empty();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic read_cnt(input int port, input int exp, input string name);
      req = 1'b1;
      idx = 2'(port);
      tick();
      req = 1'b0;
      check({name, "_valid"}, 32'(cnt_valid), 32'd1);
      check(name, 32'(cnt_out), 32'(exp));
      $display("[TB] read counter %0d -> %0d (expected %0d)", port, cnt_out, exp);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!valid_out && n < 20) begin
         tick();
         n++;
      end
      check({name, "_wait_valid"}, 32'(valid_out), 32'd1);
   endtask

   task automatic wait_drain(input string name);
      int quiet;
      int n;
      quiet = 0;
      n = 0;
      while (quiet < 3 && n < 400) begin
         tick();
         n++;
         if (!valid_out && empty == 4'hF) quiet++;
         else quiet = 0;
      end
      check({name, "_drain"}, 32'(quiet >= 3), 32'd1);
   endtask

   // ---------------- transaction-level model, checked every cycle ----------------
   int            m_last = 3;
   int            m_cnt [4];
   bit            m_busy = 1'b0;
   bit            m_busy_prev = 1'b0;
   int            m_age = 0;
   int            m_port = 0;
   logic [DW-1:0] m_word = '0;
   bit            m_pend = 1'b0;
   logic [CW-1:0] m_pend_val = '0;
   logic [CW-1:0] m_hold = '0;
   logic [3:0]    m_prev_empty = 4'hF;
   bit            m_rst_prev = 1'b1;
   bit            m_err = 1'b0;

   always @(negedge clk) begin
      bit b_start;
      int exp_p;
      int got_p;
      b_start = m_busy;
      if (m_rst_prev) begin
         check("rst_pop", 32'(pop), 32'd0);
         check("rst_valid", 32'(valid_out), 32'd0);
         check("rst_cnt_valid", 32'(cnt_valid), 32'd0);
         check("rst_data_out", 32'(data_out), 32'd0);
         check("rst_port_out", 32'(port_out), 32'd0);
         check("rst_cnt_out", 32'(cnt_out), 32'd0);
         check("rst_dest_err", 32'(dest_err), 32'd0);
         m_last = 3;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_busy = 1'b0;
         b_start = 1'b0;
         m_hold = '0;
         m_err = 1'b0;
         m_pend = 1'b0;
         if (req && !reset) begin
            m_pend = 1'b1;
            m_pend_val = '0;
         end
      end else begin
         if (m_pend) begin
            check("m_cnt_valid", 32'(cnt_valid), 32'd1);
            check("m_cnt_out", 32'(cnt_out), 32'(m_pend_val));
            m_hold = m_pend_val;
         end else begin
            check("m_cnt_valid_idle", 32'(cnt_valid), 32'd0);
            check("m_cnt_hold", 32'(cnt_out), 32'(m_hold));
         end
         m_pend = 1'b0;
         check("m_dest_err", 32'(dest_err), 32'(m_err));
         // Read captures the counter before any increment of this cycle.
         if (req && !reset) begin
            m_pend = 1'b1;
            m_pend_val = CW'(m_cnt[idx]);
         end
         if (pop != 4'b0000) begin
            check("m_pop_onehot", 32'($onehot(pop)), 32'd1);
            check("m_pop_not_empty", 32'(pop & empty), 32'd0);
            check("m_pop_after_idle", 32'(b_start || m_busy_prev), 32'd0);
            exp_p = -1;
            for (int k = 1; k <= 4; k++) begin
               if (exp_p < 0 && !m_prev_empty[(m_last + k) % 4]) exp_p = (m_last + k) % 4;
            end
            got_p = 0;
            for (int i = 0; i < 4; i++) if (pop[i]) got_p = i;
            check("m_pop_port", 32'(got_p), 32'(exp_p));
            m_last = got_p;
            m_port = got_p;
            m_busy = 1'b1;
            m_age = 0;
         end
         if (b_start) begin
            m_age++;
            if (m_age == 1) begin
               check("m_capt_valid", 32'(valid_out), 32'd0);
               m_word = rd_word[m_port];
            end else begin
               check("m_out_valid", 32'(valid_out), 32'd1);
               check("m_data_out", 32'(data_out), 32'(m_word));
               check("m_port_out", 32'(port_out), 32'(m_port));
               if (ready_in) begin
                  m_cnt[m_port] = (m_cnt[m_port] + 1) % 32;
                  m_busy = 1'b0;
                  $display("[TB] transfer port %0d data %03h count %0d", m_port, data_out, m_cnt[m_port]);
               end
            end
         end else begin
            check("m_idle_valid", 32'(valid_out), 32'd0);
         end
`ifdef EGRESS_DEST_CHECK_EN
         if (b_start && m_age == 1 && m_word[9:8] != 2'(m_port)) m_err = 1'b1;
`endif
      end
      m_busy_prev = b_start;
      m_prev_empty = empty;
      m_rst_prev = reset;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [DW-1:0] held;
      reset = 1'b1;
      ready_in = 1'b0;
      req = 1'b0;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) rd_word[i] = '0;
      upd_empty();
      tick();
      tick();
      check("reset_valid", 32'(valid_out), 32'd0);
      check("reset_pop", 32'(pop), 32'd0);
      check("reset_cnt_out", 32'(cnt_out), 32'd0);
      reset = 1'b0;
      tick();

      // Single word on port 0: pop one cycle after the IDLE cycle, valid two cycles later.
      ready_in = 1'b1;
      load(0, 12'h0A5);
      tick();
      check("t1_pop", 32'(pop), 32'h1);
      tick();
      check("t1_capt_valid", 32'(valid_out), 32'd0);
      tick();
      check("t1_valid", 32'(valid_out), 32'd1);
      check("t1_data", 32'(data_out), 32'h0A5);
      check("t1_port", 32'(port_out), 32'd0);
      tick();
      check("t1_after_xfer", 32'(valid_out), 32'd0);
      read_cnt(0, 1, "t1_cnt0");

      // All ports busy: strict round robin, one word every 4 cycles.
      do_reset();
      pop_log.delete();
      pop_cyc.delete();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 4; p++)
            load(p, 12'((k << 10) | (p << 8) | (p * 16 + k)));
      ready_in = 1'b1;
      wait_drain("t2");
      check("t2_npops", 32'(pop_log.size()), 32'd8);
      for (int k = 0; k < 8 && k < pop_log.size(); k++) begin
         check($sformatf("t2_order%0d", k), 32'(pop_log[k]), 32'(k % 4));
      end
      if (pop_cyc.size() == 8) check("t2_throughput", 32'(pop_cyc[7] - pop_cyc[0]), 32'd28);
      for (int p = 0; p < 4; p++) read_cnt(p, 2, $sformatf("t2_cnt%0d", p));

      // Backpressure: word held stable, no new pop, counter unchanged until accepted.
      ready_in = 1'b0;
      load(1, 12'h15A);
      wait_valid("t3");
      held = data_out;
      check("t3_word", 32'(held), 32'h15A);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_stable", 32'(data_out), 32'(held));
         check("t3_no_pop", 32'(pop), 32'd0);
         check("t3_valid", 32'(valid_out), 32'd1);
      end
      read_cnt(1, 2, "t3_cnt_held");
      ready_in = 1'b1;
      tick();
      check("t3_released", 32'(valid_out), 32'd0);
      read_cnt(1, 3, "t3_cnt_after");

      // Counter wrap on port 2 and read colliding with a transfer.
      do_reset();
      ready_in = 1'b1;
      for (int k = 0; k < 30; k++) load(2, 12'(12'h200 | k));
      wait_drain("t4a");
      read_cnt(2, 30, "t4_cnt30");
      load(2, 12'h2E1);
      load(2, 12'h2E2);
      wait_valid("t4");
      req = 1'b1;
      idx = 2'd2;
      tick();
      req = 1'b0;
      check("t4_collide_valid", 32'(cnt_valid), 32'd1);
      check("t4_collide_pre", 32'(cnt_out), 32'd30);
      wait_drain("t4b");
      read_cnt(2, 0, "t4_wrap");

      // Reset in the middle of OUT aborts the word and clears the counters.
      load(3, 12'h300);
      load(3, 12'h301);
      wait_valid("t5a");
      tick();
      ready_in = 1'b0;
      wait_valid("t5b");
      reset = 1'b1;
      tick();
      check("t5_valid", 32'(valid_out), 32'd0);
      check("t5_pop", 32'(pop), 32'd0);
      reset = 1'b0;
      tick();
      read_cnt(3, 0, "t5_cnt3");
      read_cnt(2, 0, "t5_cnt2");

      // Destination mismatch: port 1 carries a word addressed to 3.
      ready_in = 1'b1;
      load(1, 12'h3FF);
      wait_drain("t6");
`ifdef EGRESS_DEST_CHECK_EN
      check("t6_dest_err", 32'(dest_err), 32'd1);
      repeat (5) tick();
      check("t6_dest_sticky", 32'(dest_err), 32'd1);
`else
      check("t6_dest_err", 32'(dest_err), 32'd0);
      repeat (5) tick();
      check("t6_dest_still0", 32'(dest_err), 32'd0);
`endif
      read_cnt(1, 1, "t6_cnt1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
